branch_resolve_queue: RTL and testbench

- Producer side of the BPU execute-stage update interface; generates `bpu_es_bus1`/`bpu_es_bus2` and the front-end redirect.
- Holds a FIFO of fetch-time predictions, one entry per control-flow instruction, pushed in program order by the decode stage.
- Resolves up to two branches per cycle from EXE against the queue head, in order.
- Flags mispredictions and flushes the wrong-path entries.

---
 rtl/branch_resolve_queue_if.sv | 41 ++++
 rtl/branch_resolve_queue.sv | 141 ++++++++++++++
 tb/tb_branch_resolve_queue.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_if.sv
// Execute-stage branch update bundle: decode pushes, EXE resolves, BPU bus and redirect.
// Master drives the push/resolve/flush side, slave is the resolve queue.
`ifndef BPU_ES_BUS_WD
`define BPU_ES_BUS_WD 66
`endif

interface branch_resolve_queue_if;
  logic                      push_valid;
  logic                      push_ready;
  logic [31:0]               push_pc;
  logic                      push_taken;
  logic [31:0]               push_target;
  logic [1:0]                ex_valid;
  logic [31:0]               ex_pc1;
  logic [31:0]               ex_pc2;
  logic                      ex_taken1;
  logic                      ex_taken2;
  logic [31:0]               ex_target1;
  logic [31:0]               ex_target2;
  logic                      flush;
  logic [`BPU_ES_BUS_WD-1:0] bpu_es_bus1;
  logic [`BPU_ES_BUS_WD-1:0] bpu_es_bus2;
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;
  logic [31:0]               stat_br_cnt;
  logic [31:0]               stat_miss_cnt;

  modport master (
    output push_valid, push_pc, push_taken, push_target,
    output ex_valid, ex_pc1, ex_pc2, ex_taken1, ex_taken2, ex_target1, ex_target2, flush,
    input  push_ready, bpu_es_bus1, bpu_es_bus2, redirect_valid, redirect_pc,
    input  stat_br_cnt, stat_miss_cnt
  );

  modport slave (
    input  push_valid, push_pc, push_taken, push_target,
    input  ex_valid, ex_pc1, ex_pc2, ex_taken1, ex_taken2, ex_target1, ex_target2, flush,
    output push_ready, bpu_es_bus1, bpu_es_bus2, redirect_valid, redirect_pc,
    output stat_br_cnt, stat_miss_cnt
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// Prediction FIFO resolved in order by up to two EXE branches per cycle; drives BPU update buses
// and front-end redirect. Define BRQ_STAT_EN to build the resolved/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic                  clk,
  input logic                  resetn,
  branch_resolve_queue_if.slave brq
);

  localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_pc     [DEPTH];
  logic             r_taken  [DEPTH];
  logic [31:0]      r_target [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic [65:0]      r_bus1;
  logic [65:0]      r_bus2;
  logic             r_redirect_valid;
  logic [31:0]      r_redirect_pc;

  logic [PTR_W-1:0] w_idx2;
  logic             w_has1;
  logic             w_has2;
  logic [31:0]      w_pred_pc1;
  logic [31:0]      w_pred_pc2;
  logic             w_pred_tk1;
  logic             w_pred_tk2;
  logic [31:0]      w_pred_tg1;
  logic [31:0]      w_pred_tg2;
  logic [31:0]      w_rt1;
  logic [31:0]      w_rt2;
  logic             w_fail1;
  logic             w_fail2;
  logic             w_acc1;
  logic             w_acc2;
  logic             w_mis;
  logic             w_clear;
  logic             w_push;
  logic [1:0]       w_nacc;
  logic [1:0]       w_pops;

  assign w_idx2 = r_head + PTR_W'(1);
  assign w_has1 = (r_count != '0);
  assign w_has2 = (r_count > (PTR_W+1)'(1));

  // A slot with no backing entry behaves as a predicted not-taken fall-through of its own pc.
  assign w_pred_pc1 = w_has1 ? r_pc[r_head]     : brq.ex_pc1;
  assign w_pred_tk1 = w_has1 ? r_taken[r_head]  : 1'b0;
  assign w_pred_tg1 = w_has1 ? r_target[r_head] : brq.ex_pc1 + 32'd4;
  assign w_pred_pc2 = w_has2 ? r_pc[w_idx2]     : brq.ex_pc2;
  assign w_pred_tk2 = w_has2 ? r_taken[w_idx2]  : 1'b0;
  assign w_pred_tg2 = w_has2 ? r_target[w_idx2] : brq.ex_pc2 + 32'd4;

  assign w_rt1 = brq.ex_taken1 ? brq.ex_target1 : brq.ex_pc1 + 32'd4;
  assign w_rt2 = brq.ex_taken2 ? brq.ex_target2 : brq.ex_pc2 + 32'd4;

  assign w_fail1 = (w_pred_pc1 != brq.ex_pc1) | (brq.ex_taken1 != w_pred_tk1) |
                   (brq.ex_taken1 & (brq.ex_target1 != w_pred_tg1));
  assign w_fail2 = (w_pred_pc2 != brq.ex_pc2) | (brq.ex_taken2 != w_pred_tk2) |
                   (brq.ex_taken2 & (brq.ex_target2 != w_pred_tg2));

  assign w_acc1  = brq.ex_valid[0] & ~brq.flush;
  assign w_acc2  = w_acc1 & brq.ex_valid[1] & ~w_fail1;
  assign w_mis   = (w_acc1 & w_fail1) | (w_acc2 & w_fail2);
  assign w_clear = brq.flush | w_mis;
  assign w_nacc  = {1'b0, w_acc1} + {1'b0, w_acc2};
  assign w_pops  = ((PTR_W+1)'(w_nacc) > r_count) ? r_count[1:0] : w_nacc;

  assign brq.push_ready = (r_count != L_DEPTH);
  assign w_push         = brq.push_valid & brq.push_ready & ~w_clear;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail]     <= brq.push_pc;
      r_taken[r_tail]  <= brq.push_taken;
      r_target[r_tail] <= brq.push_target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_bus1           <= '0;
      r_bus2           <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      if (w_clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PTR_W'(w_pops);
        r_tail  <= r_tail + PTR_W'(w_push);
        r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pops);
      end
      r_bus1           <= w_acc1 ? {brq.ex_pc1, brq.ex_taken1, w_fail1, w_rt1} : '0;
      r_bus2           <= w_acc2 ? {brq.ex_pc2, brq.ex_taken2, w_fail2, w_rt2} : '0;
      r_redirect_valid <= w_mis;
      r_redirect_pc    <= !w_mis ? '0 : ((w_acc1 & w_fail1) ? w_rt1 : w_rt2);
    end
  end

  assign brq.bpu_es_bus1    = r_bus1;
  assign brq.bpu_es_bus2    = r_bus2;
  assign brq.redirect_valid = r_redirect_valid;
  assign brq.redirect_pc    = r_redirect_pc;

`ifdef BRQ_STAT_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_miss;
  logic [32:0] w_br_sum;

  assign w_br_sum = {1'b0, r_stat_br} + 33'(w_nacc);

  // Counters saturate and survive pipeline flushes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_br   <= '0;
      r_stat_miss <= '0;
    end else begin
      r_stat_br <= w_br_sum[32] ? '1 : w_br_sum[31:0];
      if (w_mis && (r_stat_miss != '1)) r_stat_miss <= r_stat_miss + 32'd1;
    end
  end

  assign brq.stat_br_cnt   = r_stat_br;
  assign brq.stat_miss_cnt = r_stat_miss;
`else
  assign brq.stat_br_cnt   = 32'h0;
  assign brq.stat_miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a randomized run
// scored against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_queue_if bi();
  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (.clk(clk), .resetn(resetn), .brq(bi));

  int n_tests = 0;
  int n_fail  = 0;

  pred_t       q[$];
  logic [65:0] exp_bus1, exp_bus2;
  logic        exp_rv;
  logic [31:0] exp_rpc;
  longint      exp_br = 0, exp_miss = 0;
  logic [31:0] exp_stat_br, exp_stat_miss;

  function automatic void model_slot(input logic [31:0] ex_pc, input logic tk, input logic [31:0] tg,
                                     input int idx, output logic fail, output logic [31:0] rt);
    pred_t p;
    if (idx < q.size()) p = q[idx];
    else begin
      p.pc = ex_pc; p.taken = 1'b0; p.target = ex_pc + 32'd4;
    end
    rt   = tk ? tg : ex_pc + 32'd4;
    fail = (p.pc != ex_pc) || (tk != p.taken) || (tk && (tg != p.target));
  endfunction

  function automatic void set_stat_exp();
`ifdef BRQ_STAT_EN
    exp_stat_br   = (exp_br > 64'hFFFFFFFF) ? 32'hFFFFFFFF : exp_br[31:0];
    exp_stat_miss = (exp_miss > 64'hFFFFFFFF) ? 32'hFFFFFFFF : exp_miss[31:0];
`else
    exp_stat_br   = 32'h0;
    exp_stat_miss = 32'h0;
`endif
  endfunction

  // Drives one cycle of inputs, advances the model, returns #1 after the capturing edge.
  task automatic cycle(input logic pv, input logic [31:0] ppc, input logic ptk, input logic [31:0] ptg,
                       input logic [1:0] exv,
                       input logic [31:0] pc1, input logic tk1, input logic [31:0] tg1,
                       input logic [31:0] pc2, input logic tk2, input logic [31:0] tg2,
                       input logic fl);
    logic        f1, f2, mis, ready;
    logic [31:0] rt1, rt2;
    int          acc;
    pred_t       e;
    @(negedge clk);
    bi.push_valid = pv; bi.push_pc = ppc; bi.push_taken = ptk; bi.push_target = ptg;
    bi.ex_valid = exv; bi.ex_pc1 = pc1; bi.ex_taken1 = tk1; bi.ex_target1 = tg1;
    bi.ex_pc2 = pc2; bi.ex_taken2 = tk2; bi.ex_target2 = tg2; bi.flush = fl;
    exp_bus1 = '0; exp_bus2 = '0; exp_rv = 1'b0; exp_rpc = '0;
    if (fl) q.delete();
    else begin
      ready = (q.size() < DEPTH);
      acc = 0; mis = 1'b0;
      if (exv[0]) begin
        model_slot(pc1, tk1, tg1, 0, f1, rt1);
        exp_bus1 = {pc1, tk1, f1, rt1};
        acc = 1;
        if (f1) begin
          mis = 1'b1; exp_rpc = rt1;
        end else if (exv[1]) begin
          model_slot(pc2, tk2, tg2, 1, f2, rt2);
          exp_bus2 = {pc2, tk2, f2, rt2};
          acc = 2;
          if (f2) begin
            mis = 1'b1; exp_rpc = rt2;
          end
        end
      end
      exp_rv = mis;
      exp_br += acc;
      if (mis) exp_miss++;
      if (mis) q.delete();
      else begin
        repeat (acc) if (q.size() > 0) void'(q.pop_front());
        if (pv && ready) begin
          e.pc = ppc; e.taken = ptk; e.target = ptg;
          q.push_back(e);
        end
      end
    end
    set_stat_exp();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    cycle(1'b1, pc, tk, tg, 2'b00, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 2'b00, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (bi.push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bi.push_ready); end
    n_tests++;
    if ({bi.bpu_es_bus1, bi.bpu_es_bus2, bi.redirect_valid, bi.redirect_pc} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h %h %b %h exp 0", bi.bpu_es_bus1, bi.bpu_es_bus2,
                         bi.redirect_valid, bi.redirect_pc);
    end
    n_tests++;
    if ({bi.stat_br_cnt, bi.stat_miss_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_stats got %h %h exp 0", bi.stat_br_cnt, bi.stat_miss_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_correct_taken();
    push(32'h1c000010, 1'b1, 32'h1c000040);
    cycle(1'b0, '0, 1'b0, '0, 2'b01, 32'h1c000010, 1'b1, 32'h1c000040, '0, 1'b0, '0, 1'b0);
    n_tests++;
    if (bi.bpu_es_bus1 !== {32'h1c000010, 1'b1, 1'b0, 32'h1c000040}) begin
      n_fail++; $display("FAIL hit_bus1 got %h exp %h", bi.bpu_es_bus1, {32'h1c000010, 1'b1, 1'b0, 32'h1c000040});
    end
    n_tests++;
    if (bi.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL hit_redirect got %b exp 0", bi.redirect_valid); end
    idle();
    n_tests++;
    if (bi.bpu_es_bus1 !== '0) begin n_fail++; $display("FAIL hit_bus1_idle got %h exp 0", bi.bpu_es_bus1); end
  endtask

  task automatic test_mispredict_taken();
    push(32'h1c000020, 1'b0, 32'h1c000024);
    cycle(1'b0, '0, 1'b0, '0, 2'b01, 32'h1c000020, 1'b1, 32'h1c000100, '0, 1'b0, '0, 1'b0);
    n_tests++;
    if (bi.bpu_es_bus1 !== {32'h1c000020, 1'b1, 1'b1, 32'h1c000100}) begin
      n_fail++; $display("FAIL miss_bus1 got %h exp %h", bi.bpu_es_bus1, {32'h1c000020, 1'b1, 1'b1, 32'h1c000100});
    end
    n_tests++;
    if ({bi.redirect_valid, bi.redirect_pc} !== {1'b1, 32'h1c000100}) begin
      n_fail++; $display("FAIL miss_redirect got %b %h exp 1 1c000100", bi.redirect_valid, bi.redirect_pc);
    end
    idle();
    n_tests++;
    if (bi.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL miss_pulse got %b exp 0", bi.redirect_valid); end
  endtask

  task automatic test_slot2_squash();
    push(32'h1c000200, 1'b1, 32'h1c000280);
    push(32'h1c000210, 1'b0, 32'h1c000214);
    push(32'h1c000220, 1'b0, 32'h1c000224);
    cycle(1'b1, 32'h1c000500, 1'b0, 32'h1c000504, 2'b11, 32'h1c000200, 1'b0, 32'h0,
          32'h1c000210, 1'b0, 32'h1c000214, 1'b0);
    n_tests++;
    if (bi.bpu_es_bus1 !== {32'h1c000200, 1'b0, 1'b1, 32'h1c000204}) begin
      n_fail++; $display("FAIL sq_bus1 got %h exp %h", bi.bpu_es_bus1, {32'h1c000200, 1'b0, 1'b1, 32'h1c000204});
    end
    n_tests++;
    if (bi.bpu_es_bus2 !== '0) begin n_fail++; $display("FAIL sq_bus2 got %h exp 0", bi.bpu_es_bus2); end
    n_tests++;
    if ({bi.redirect_valid, bi.redirect_pc} !== {1'b1, 32'h1c000204}) begin
      n_fail++; $display("FAIL sq_redirect got %b %h exp 1 1c000204", bi.redirect_valid, bi.redirect_pc);
    end
    push(32'h1c000300, 1'b0, 32'h1c000304);
    cycle(1'b0, '0, 1'b0, '0, 2'b01, 32'h1c000300, 1'b0, 32'h0, '0, 1'b0, '0, 1'b0);
    n_tests++;
    if ({bi.bpu_es_bus1, bi.redirect_valid} !== {32'h1c000300, 1'b0, 1'b0, 32'h1c000304, 1'b0}) begin
      n_fail++; $display("FAIL sq_empty got %h %b exp 1c000300 0 0 1c000304 0", bi.bpu_es_bus1, bi.redirect_valid);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] pc;
    for (int i = 0; i < DEPTH; i++) push(32'h1c001000 + 32'(i * 16), 1'(i % 2), 32'h1c002000 + 32'(i * 8));
    n_tests++;
    if (bi.push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", bi.push_ready); end
    push(32'h1c009990, 1'b1, 32'h1c009000);
    n_tests++;
    if (bi.push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ninth got %b exp 0", bi.push_ready); end
    cycle(1'b0, '0, 1'b0, '0, 2'b11, 32'h1c001000, 1'b0, 32'h0, 32'h1c001010, 1'b1, 32'h1c002008, 1'b0);
    n_tests++;
    if (bi.push_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready got %b exp 1", bi.push_ready); end
    push(32'h1c00a000, 1'b1, 32'h1c00a400);
    for (int i = 2; i < DEPTH; i += 2) begin
      pc = 32'h1c001000 + 32'(i * 16);
      cycle(1'b0, '0, 1'b0, '0, 2'b11, pc, 1'(i % 2), 32'h1c002000 + 32'(i * 8),
            pc + 32'd16, 1'((i + 1) % 2), 32'h1c002000 + 32'((i + 1) * 8), 1'b0);
      n_tests++;
      if ({bi.bpu_es_bus1, bi.bpu_es_bus2, bi.redirect_valid} !== {exp_bus1, exp_bus2, 1'b0}) begin
        n_fail++; $display("FAIL full_drain%0d got %h %h %b exp %h %h 0", i, bi.bpu_es_bus1, bi.bpu_es_bus2,
                           bi.redirect_valid, exp_bus1, exp_bus2);
      end
    end
    cycle(1'b0, '0, 1'b0, '0, 2'b01, 32'h1c00a000, 1'b1, 32'h1c00a400, '0, 1'b0, '0, 1'b0);
    n_tests++;
    if ({bi.bpu_es_bus1, bi.redirect_valid} !== {32'h1c00a000, 1'b1, 1'b0, 32'h1c00a400, 1'b0}) begin
      n_fail++; $display("FAIL wrap_entry got %h %b exp 1c00a000 1 0 1c00a400 0", bi.bpu_es_bus1, bi.redirect_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] br_before;
    push(32'h1c000400, 1'b0, 32'h1c000404);
    push(32'h1c000410, 1'b0, 32'h1c000414);
    br_before = bi.stat_br_cnt;
    cycle(1'b1, 32'h1c000600, 1'b0, 32'h1c000604, 2'b11, 32'h1c000400, 1'b0, 32'h0,
          32'h1c000410, 1'b0, 32'h0, 1'b1);
    n_tests++;
    if ({bi.bpu_es_bus1, bi.bpu_es_bus2, bi.redirect_valid} !== '0) begin
      n_fail++; $display("FAIL flush_out got %h %h %b exp 0", bi.bpu_es_bus1, bi.bpu_es_bus2, bi.redirect_valid);
    end
    n_tests++;
    if (bi.stat_br_cnt !== br_before) begin
      n_fail++; $display("FAIL flush_stat got %h exp %h", bi.stat_br_cnt, br_before);
    end
    push(32'h1c000700, 1'b0, 32'h1c000704);
    cycle(1'b0, '0, 1'b0, '0, 2'b01, 32'h1c000700, 1'b0, 32'h0, '0, 1'b0, '0, 1'b0);
    n_tests++;
    if ({bi.bpu_es_bus1, bi.redirect_valid} !== {32'h1c000700, 1'b0, 1'b0, 32'h1c000704, 1'b0}) begin
      n_fail++; $display("FAIL flush_empty got %h %b", bi.bpu_es_bus1, bi.redirect_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc1, pc2, tg1, tg2, ppc, ptg;
    logic        tk1, tk2;
    for (int n = 0; n < 600; n++) begin
      pc1 = $urandom() & ~32'h3; tk1 = 1'($urandom()); tg1 = $urandom() & ~32'h3;
      pc2 = $urandom() & ~32'h3; tk2 = 1'($urandom()); tg2 = $urandom() & ~32'h3;
      if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
        pc1 = q[0].pc;
        if ($urandom_range(0, 3) != 0) begin tk1 = q[0].taken; tg1 = q[0].target; end
      end
      if (q.size() > 1 && $urandom_range(0, 7) != 0) begin
        pc2 = q[1].pc;
        if ($urandom_range(0, 3) != 0) begin tk2 = q[1].taken; tg2 = q[1].target; end
      end
      ppc = $urandom() & ~32'h3; ptg = $urandom() & ~32'h3;
      cycle(1'($urandom_range(0, 2) != 0), ppc, 1'($urandom()), ptg, 2'($urandom()),
            pc1, tk1, tg1, pc2, tk2, tg2, 1'($urandom_range(0, 40) == 0));
      n_tests++;
      if ({bi.bpu_es_bus1, bi.bpu_es_bus2} !== {exp_bus1, exp_bus2}) begin
        n_fail++; $display("FAIL rnd_bus%0d got %h %h exp %h %h", n, bi.bpu_es_bus1, bi.bpu_es_bus2, exp_bus1, exp_bus2);
      end
      n_tests++;
      if ({bi.redirect_valid, bi.redirect_pc} !== {exp_rv, exp_rpc}) begin
        n_fail++; $display("FAIL rnd_redir%0d got %b %h exp %b %h", n, bi.redirect_valid, bi.redirect_pc, exp_rv, exp_rpc);
      end
      n_tests++;
      if (bi.push_ready !== (q.size() != DEPTH)) begin
        n_fail++; $display("FAIL rnd_ready%0d got %b exp %b", n, bi.push_ready, q.size() != DEPTH);
      end
      n_tests++;
      if ({bi.stat_br_cnt, bi.stat_miss_cnt} !== {exp_stat_br, exp_stat_miss}) begin
        n_fail++; $display("FAIL rnd_stat%0d got %h %h exp %h %h", n, bi.stat_br_cnt, bi.stat_miss_cnt,
                           exp_stat_br, exp_stat_miss);
      end
    end
  endtask

  task automatic test_reset_midstream();
    while (q.size() > 0) idle();
    for (int i = 0; i < 5; i++) push(32'h1c003000 + 32'(i * 4), 1'b0, 32'h1c003004 + 32'(i * 4));
    cycle(1'b0, '0, 1'b0, '0, 2'b11, 32'h1c003000, 1'b0, 32'h0, 32'h1c003004, 1'b1, 32'h1c003300, 1'b0);
    resetn = 1'b0;
    #1;
    q.delete(); exp_br = 0; exp_miss = 0;
    n_tests++;
    if ({bi.bpu_es_bus1, bi.bpu_es_bus2, bi.redirect_valid, bi.redirect_pc} !== '0) begin
      n_fail++; $display("FAIL mrst_out got %h %h %b %h exp 0", bi.bpu_es_bus1, bi.bpu_es_bus2,
                         bi.redirect_valid, bi.redirect_pc);
    end
    n_tests++;
    if ({bi.push_ready, bi.stat_br_cnt, bi.stat_miss_cnt} !== {1'b1, 64'h0}) begin
      n_fail++; $display("FAIL mrst_state got %b %h %h exp 1 0 0", bi.push_ready, bi.stat_br_cnt, bi.stat_miss_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    push(32'h1c004000, 1'b0, 32'h1c004004);
    cycle(1'b0, '0, 1'b0, '0, 2'b01, 32'h1c004000, 1'b0, 32'h0, '0, 1'b0, '0, 1'b0);
    n_tests++;
    if ({bi.bpu_es_bus1, bi.redirect_valid} !== {32'h1c004000, 1'b0, 1'b0, 32'h1c004004, 1'b0}) begin
      n_fail++; $display("FAIL mrst_empty got %h %b", bi.bpu_es_bus1, bi.redirect_valid);
    end
  endtask

  initial begin
    bi.push_valid = 1'b0; bi.push_pc = '0; bi.push_taken = 1'b0; bi.push_target = '0;
    bi.ex_valid = 2'b00; bi.ex_pc1 = '0; bi.ex_pc2 = '0; bi.ex_taken1 = 1'b0; bi.ex_taken2 = 1'b0;
    bi.ex_target1 = '0; bi.ex_target2 = '0; bi.flush = 1'b0;
    test_reset();
    test_correct_taken();
    test_mispredict_taken();
    test_slot2_squash();
    test_full_wrap();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded 500000 time units");
    $fatal(1, "timeout");
  end
endmodule
